sdram_slave_model: RTL and testbench

// Avalon-MM responder that acts as the memory end of the loop recorder's sample-store interface.

---
 rtl/sdram_slave_model.sv | 188 ++++++++++++++++++
 tb/tb_sdram_slave_model.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_slave_model.sv
`default_nettype none
// ============================================================================
// Module   : sdram_slave_model
// Brief    : Avalon-MM memory responder with programmable wait states and a
//            fixed-latency read return, backed by an on-chip word array.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_slave_model #(
    parameter int ADDR_BITS    = 10,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] address,
    input  logic        chipselect,
    input  logic [3:0]  byteenable_n,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest,
    output logic        collision,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int         c_depth     = 2 ** ADDR_BITS;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_accept = 2'd2;
    localparam logic [3:0] c_wait      = 4'(WAIT_CYCLES);
    localparam logic [3:0] c_wait_last = c_wait - 4'd1;

    logic [1:0]                        state_q, state_d;
    logic [3:0]                        wcnt_q, wcnt_d;
    logic [READ_LATENCY-1:0]           vld_q, vld_d;
    logic [READ_LATENCY-1:0][31:0]     dat_q, dat_d;
    logic                              collision_q, collision_d;
    logic [15:0]                       wr_count_q, wr_count_d;
    logic [15:0]                       rd_count_q, rd_count_d;
    logic [31:0]                       mem_q [c_depth];

    logic                              w_req;
    logic                              w_accept;
    logic                              w_wr_en;
    logic                              w_rd_en;
    logic [ADDR_BITS-1:0]              w_idx;
    logic [31:0]                       w_rd_word;
    logic [31:0]                       w_mem_wdata;
    logic [READ_LATENCY:0]             w_vld_chain;
    logic [READ_LATENCY:0][31:0]       w_dat_chain;
    logic                              w_unused_addr;

    assign w_req         = chipselect & (~read_n | ~write_n);
    assign w_idx         = address[ADDR_BITS-1:0];
    assign w_unused_addr = ^address[24:ADDR_BITS];
    assign w_rd_word     = mem_q[w_idx];

    // ---------------- handshake FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_st_idle;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // ---------------- handshake FSM: next state ----------------
    // The IDLE cycle in which a request first appears already counts as one
    // wait cycle, so every request sees exactly WAIT_CYCLES waitrequest-high cycles.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (WAIT_CYCLES == 0) begin
            state_d = w_req ? c_st_accept : c_st_idle;
            wcnt_d  = 4'd0;
        end else begin
            case (state_q)
                c_st_idle: begin
                    if (w_req) begin
                        if (c_wait == 4'd1) begin
                            state_d = c_st_accept;
                            wcnt_d  = 4'd0;
                        end else begin
                            state_d = c_st_wait;
                            wcnt_d  = 4'd1;
                        end
                    end
                end
                c_st_wait: begin
                    if (!w_req) begin
                        state_d = c_st_idle;
                        wcnt_d  = 4'd0;
                    end else if (wcnt_q == c_wait_last) begin
                        state_d = c_st_accept;
                        wcnt_d  = 4'd0;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
                c_st_accept: begin
                    state_d = w_req ? c_st_wait : c_st_idle;
                    wcnt_d  = 4'd0;
                end
                default: begin
                    state_d = c_st_idle;
                    wcnt_d  = 4'd0;
                end
            endcase
        end
    end

    // ---------------- handshake FSM: outputs ----------------
    always_comb begin
        waitrequest = 1'b1;
        w_accept    = 1'b0;
        if (!reset) begin
            if (WAIT_CYCLES == 0) begin
                waitrequest = 1'b0;
                w_accept    = w_req;
            end else begin
                waitrequest = w_req && (state_q != c_st_accept);
                w_accept    = w_req && (state_q == c_st_accept);
            end
        end
    end

    // ---------------- transfer decode and counters ----------------
    // A collision is resolved as a write: no read enters the return pipe.
    always_comb begin
        w_wr_en     = w_accept & ~write_n;
        w_rd_en     = w_accept & ~read_n & write_n;
        collision_d = w_accept & ~read_n & ~write_n;
        wr_count_d  = (w_wr_en && (wr_count_q != 16'hFFFF)) ? wr_count_q + 16'd1 : wr_count_q;
        rd_count_d  = (w_rd_en && (rd_count_q != 16'hFFFF)) ? rd_count_q + 16'd1 : rd_count_q;
        w_mem_wdata = w_rd_word;
        for (int b = 0; b < 4; b++) begin
            if (!byteenable_n[b]) w_mem_wdata[8*b +: 8] = writedata[8*b +: 8];
        end
    end

    // ---------------- read return pipe ----------------
    // Data stages only load alongside a valid bit, so the last stage holds its
    // previous word while readdatavalid is low.
    assign w_vld_chain = {vld_q, w_rd_en};
    assign w_dat_chain = {dat_q, w_rd_word};

    always_comb begin
        vld_d = w_vld_chain[READ_LATENCY-1:0];
        dat_d = dat_q;
        for (int k = 0; k < READ_LATENCY; k++) begin
            if (w_vld_chain[k]) dat_d[k] = w_dat_chain[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q       <= '0;
            dat_q       <= '0;
            collision_q <= 1'b0;
            wr_count_q  <= 16'd0;
            rd_count_q  <= 16'd0;
        end else begin
            vld_q       <= vld_d;
            dat_q       <= dat_d;
            collision_q <= collision_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
        end
    end

    // Storage survives reset so a recorded loop can be read back afterwards.
    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[w_idx] <= w_mem_wdata;
    end

    assign readdata      = dat_q[READ_LATENCY-1];
    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign collision     = collision_q;
    assign wr_count      = wr_count_q;
    assign rd_count      = rd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_slave_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_slave_model
// Brief    : Randomised bench for sdram_slave_model with a scoreboard model;
//            drives one W=2/L=2 and one W=0/L=3 instance from shared inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_slave_model;

    localparam int W_A = 2;
    localparam int L_A = 2;
    localparam int W_B = 0;
    localparam int L_B = 3;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        int          due;
    } rd_exp_t;

    logic        clk;
    logic        reset;
    logic [24:0] address;
    logic        cs_a, cs_b;
    logic [3:0]  byteenable_n;
    logic        read_n, write_n;
    logic [31:0] writedata;
    logic [31:0] readdata_a, readdata_b;
    logic        rdv_a, rdv_b, wait_a, wait_b, coll_a, coll_b;
    logic [15:0] wr_count_a, rd_count_a, wr_count_b, rd_count_b;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] m_mem   [2][1024];
    logic [3:0]  m_known [2][1024];
    int          m_wr [2];
    int          m_rd [2];
    rd_exp_t     q_a[$], q_b[$];
    bit          coll_due_a[int], coll_due_b[int];
    rd_exp_t     e_a, e_b;

    sdram_slave_model #(.ADDR_BITS(10), .WAIT_CYCLES(W_A), .READ_LATENCY(L_A)) u_dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
        .byteenable_n(byteenable_n), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(readdata_a), .readdatavalid(rdv_a),
        .waitrequest(wait_a), .collision(coll_a), .wr_count(wr_count_a), .rd_count(rd_count_a)
    );

    sdram_slave_model #(.ADDR_BITS(10), .WAIT_CYCLES(W_B), .READ_LATENCY(L_B)) u_dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
        .byteenable_n(byteenable_n), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(readdata_b), .readdatavalid(rdv_b),
        .waitrequest(wait_b), .collision(coll_b), .wr_count(wr_count_b), .rd_count(rd_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic wait_of(input int sel);
        return (sel == 1) ? wait_b : wait_a;
    endfunction

    // Read returns and collision pulses are checked every cycle against the scoreboard.
    always @(negedge clk) begin
        if (rdv_a) begin
            if (q_a.size() == 0) check_eq("rdv_a_spurious", 32'd1, 32'd0);
            else begin
                e_a = q_a.pop_front();
                check_eq("rdv_a_cycle", cyc, e_a.due);
                check_eq("rdata_a", readdata_a & e_a.mask, e_a.data);
            end
        end else if (q_a.size() != 0 && q_a[0].due < cyc) begin
            check_eq("rdv_a_missing", 32'd0, 32'd1);
            void'(q_a.pop_front());
        end
        if (rdv_b) begin
            if (q_b.size() == 0) check_eq("rdv_b_spurious", 32'd1, 32'd0);
            else begin
                e_b = q_b.pop_front();
                check_eq("rdv_b_cycle", cyc, e_b.due);
                check_eq("rdata_b", readdata_b & e_b.mask, e_b.data);
            end
        end else if (q_b.size() != 0 && q_b[0].due < cyc) begin
            check_eq("rdv_b_missing", 32'd0, 32'd1);
            void'(q_b.pop_front());
        end
        check_eq("collision_a", 32'(coll_a), 32'(coll_due_a.exists(cyc)));
        check_eq("collision_b", 32'(coll_b), 32'(coll_due_b.exists(cyc)));
        if (coll_due_a.exists(cyc)) coll_due_a.delete(cyc);
        if (coll_due_b.exists(cyc)) coll_due_b.delete(cyc);
    end

    task automatic drop_inputs();
        cs_a = 1'b0; cs_b = 1'b0; read_n = 1'b1; write_n = 1'b1;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        drop_inputs();
        repeat (n) begin
            @(negedge clk);
            check_eq("idle_wait_a", 32'(wait_a), 32'd0);
            check_eq("idle_wait_b", 32'(wait_b), 32'd0);
        end
    endtask

    // One master transfer: hold the request until waitrequest is seen low,
    // then record its effect in the model as of the acceptance edge.
    task automatic xfer(input int sel, input bit rd, input bit wr, input logic [24:0] addr,
                        input logic [3:0] be_n, input logic [31:0] data);
        int          waits;
        bit          done;
        int          idx;
        logic [31:0] mask;
        rd_exp_t     e;
        @(posedge clk); #1;
        cs_a = (sel == 0); cs_b = (sel == 1);
        address = addr; read_n = !rd; write_n = !wr; byteenable_n = be_n; writedata = data;
        waits = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (wait_of(sel)) waits++;
            else done = 1;
        end
        check_eq("accepted", 32'(done), 32'd1);
        check_eq("wait_cycles", waits, (sel == 1) ? W_B : W_A);
        if (!done) begin
            drop_inputs();
            return;
        end
        idx = int'(addr[9:0]);
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (!be_n[b]) begin
                    m_mem[sel][idx][8*b +: 8] = data[8*b +: 8];
                    m_known[sel][idx][b] = 1'b1;
                end
            end
            if (m_wr[sel] < 65535) m_wr[sel]++;
            if (rd) begin
                if (sel == 1) coll_due_b[cyc + 1] = 1'b1;
                else          coll_due_a[cyc + 1] = 1'b1;
            end
        end else if (rd) begin
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{m_known[sel][idx][b]}};
            e.data = m_mem[sel][idx] & mask;
            e.mask = mask;
            e.due  = cyc + ((sel == 1) ? L_B : L_A);
            if (sel == 1) q_b.push_back(e);
            else          q_a.push_back(e);
            if (m_rd[sel] < 65535) m_rd[sel]++;
        end
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_wr_a"}, 32'(wr_count_a), m_wr[0]);
        check_eq({tag, "_rd_a"}, 32'(rd_count_a), m_rd[0]);
        check_eq({tag, "_wr_b"}, 32'(wr_count_b), m_wr[1]);
        check_eq({tag, "_rd_b"}, 32'(rd_count_b), m_rd[1]);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        drop_inputs();
        q_a.delete(); q_b.delete();
        coll_due_a.delete(); coll_due_b.delete();
        m_wr[0] = 0; m_wr[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
        repeat (n) begin
            @(negedge clk);
            check_eq("reset_wait_a", 32'(wait_a), 32'd1);
            check_eq("reset_wait_b", 32'(wait_b), 32'd1);
        end
        check_eq("reset_rdata_a", readdata_a, 32'd0);
        check_eq("reset_rdata_b", readdata_b, 32'd0);
        check_counts("reset");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          op, sel;
        logic [24:0] a;
        logic [3:0]  be;
        logic [31:0] d;

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 1024; i++) begin
                m_mem[s][i] = 32'd0;
                m_known[s][i] = 4'd0;
            end
            m_wr[s] = 0; m_rd[s] = 0;
        end
        reset = 1'b1; address = '0; byteenable_n = 4'hF; writedata = '0;
        drop_inputs();
        do_reset(3);

        // W=2 instance: basic write/read, partial write, alias, collision
        xfer(0, 0, 1, 25'h10, 4'h0, 32'hDEADBEEF);
        idle(1);
        check_counts("after_write");
        xfer(0, 1, 0, 25'h10, 4'h0, 32'h0);
        idle(4);
        check_counts("after_read");
        xfer(0, 0, 1, 25'h20, 4'h0, 32'h11223344);
        xfer(0, 0, 1, 25'h20, 4'b1010, 32'hAABBCCDD);
        xfer(0, 1, 0, 25'h20, 4'h0, 32'h0);
        xfer(0, 0, 1, 25'h400, 4'h0, 32'hCAFEF00D);
        xfer(0, 1, 0, 25'h000, 4'h0, 32'h0);
        xfer(0, 1, 1, 25'h30, 4'h0, 32'h5A5A1234);
        xfer(0, 1, 0, 25'h30, 4'h0, 32'h0);
        xfer(0, 0, 1, 25'h40, 4'hF, 32'hFFFFFFFF);
        idle(4);
        check_counts("directed_a");

        // request withdrawn during wait states: no transfer
        @(posedge clk); #1;
        cs_a = 1'b1; write_n = 1'b0; read_n = 1'b1; address = 25'h10;
        byteenable_n = 4'h0; writedata = 32'h0BAD0BAD;
        @(negedge clk);
        check_eq("abort_wait", 32'(wait_a), 32'd1);
        idle(3);
        check_counts("abort");
        xfer(0, 1, 0, 25'h10, 4'h0, 32'h0);

        // W=0 instance: fill then four back-to-back reads
        for (int i = 0; i < 4; i++) xfer(1, 0, 1, 25'(i), 4'h0, 32'h1000_0000 * (i + 1) + 32'(i));
        for (int i = 0; i < 4; i++) xfer(1, 1, 0, 25'(i), 4'h0, 32'h0);
        idle(6);
        check_counts("directed_b");

        // reset while reads are in flight, then memory must still read back
        xfer(1, 1, 0, 25'h1, 4'h0, 32'h0);
        xfer(1, 1, 0, 25'h2, 4'h0, 32'h0);
        xfer(0, 1, 0, 25'h10, 4'h0, 32'h0);
        do_reset(2);
        idle(6);
        check_counts("post_reset");
        xfer(0, 1, 0, 25'h10, 4'h0, 32'h0);
        xfer(1, 1, 0, 25'h3, 4'h0, 32'h0);
        idle(5);

        // randomised traffic over a small address pool with aliasing upper bits
        for (int i = 0; i < 300; i++) begin
            op  = int'($urandom_range(0, 9));
            sel = int'($urandom_range(0, 1));
            a   = {15'($urandom), 10'($urandom_range(0, 7))};
            be  = (op < 2) ? 4'h0 : 4'($urandom);
            d   = $urandom;
            if (op < 4)       xfer(sel, 0, 1, a, be, d);
            else if (op < 8)  xfer(sel, 1, 0, a, be, d);
            else if (op == 8) xfer(sel, 1, 1, a, be, d);
            else              idle(int'($urandom_range(1, 3)));
        end
        idle(6);
        check_eq("queue_a_drained", q_a.size(), 0);
        check_eq("queue_b_drained", q_b.size(), 0);
        check_counts("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
